// File: rtl/rom_load_ctrl.sv
// Purpose : ROM download sequencer; qualifies the ioctl stream by index, registers
//           writes into the EPROM bank, counts bytes and holds the core in reset.
// Latency : one cycle ioctl_wr -> dl_wr; rom_loaded rises HOLD_CYCLES+1 cycles after download drops.
// Backpr. : ioctl_wait held high for WR_GAP cycles after every accepted write (LOAD only).
//
// Ports:
//   CLK, RESET          single clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout   HPS download stream
//   ioctl_wait          pacing back-pressure to the HPS
//   dl_wr/dl_addr/dl_data  registered write to the EPROM bank (address decode is downstream)
//   core_reset          reset for CPUs and video, released only in RUN
//   rom_loaded          image loaded and core running
//   load_error          last load's byte count differed from ROM_SIZE
//   byte_count          bytes accepted in the current or last load
module rom_load_ctrl #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [24:0] ROM_SIZE    = 25'h58300,
  parameter int          HOLD_CYCLES = 16,
  parameter int          WR_GAP      = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        dl_wr,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        load_error,
  output logic [24:0] byte_count
);

  localparam int GAP_W  = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               rom_match;

  assign rom_match = ioctl_download && (ioctl_index == ROM_INDEX);

  // gap_cnt is cleared whenever LOAD is left, but the state qualifier also
  // covers the cycle right after a write that coincides with download end.
  assign ioctl_wait = (state == ST_LOAD) && (gap_cnt != '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      hold_cnt   <= '0;
      dl_wr      <= 1'b0;
      dl_addr    <= '0;
      dl_data    <= '0;
      core_reset <= 1'b1;
      rom_loaded <= 1'b0;
      load_error <= 1'b0;
      byte_count <= '0;
    end else begin
      dl_wr <= 1'b0;

      case (state)
        ST_IDLE: begin
          core_reset <= 1'b1;
          rom_loaded <= 1'b0;
          gap_cnt    <= '0;
          if (rom_match) begin
            state      <= ST_LOAD;
            byte_count <= '0;
            load_error <= 1'b0;
          end
        end

        ST_LOAD: begin
          core_reset <= 1'b1;
          rom_loaded <= 1'b0;
          // A write is accepted even while ioctl_wait is up; it restarts the gap.
          if (ioctl_wr) begin
            dl_wr   <= 1'b1;
            dl_addr <= ioctl_addr;
            dl_data <= ioctl_dout;
            gap_cnt <= GAP_W'(WR_GAP);
            if (byte_count != '1)
              byte_count <= byte_count + 25'd1;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
          // Download end does not cancel a write sampled on the same edge.
          if (!ioctl_download) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
          end
        end

        ST_HOLD: begin
          core_reset <= 1'b1;
          rom_loaded <= 1'b0;
          gap_cnt    <= '0;
          if (hold_cnt == '0) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            rom_loaded <= 1'b1;
            load_error <= (byte_count != ROM_SIZE);
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        ST_RUN: begin
          core_reset <= 1'b0;
          rom_loaded <= 1'b1;
          gap_cnt    <= '0;
          if (rom_match) begin
            state      <= ST_LOAD;
            core_reset <= 1'b1;
            rom_loaded <= 1'b0;
            byte_count <= '0;
            load_error <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
module tb_rom_load_ctrl;

  localparam logic [24:0] SIZE = 25'h40;
  localparam int          HOLD = 16;
  localparam int          GAP  = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        core_reset;
  logic        rom_loaded;
  logic        load_error;
  logic [24:0] byte_count;

  int checks   = 0;
  int failures = 0;
  int wait_hi;
  int wr_seen;

  rom_load_ctrl #(
    .ROM_INDEX   (8'd0),
    .ROM_SIZE    (SIZE),
    .HOLD_CYCLES (HOLD),
    .WR_GAP      (GAP)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dl_wr          (dl_wr),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .core_reset     (core_reset),
    .rom_loaded     (rom_loaded),
    .load_error     (load_error),
    .byte_count     (byte_count)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_rom_loaded"}, 32'(rom_loaded), 32'd0);
    check({tag, "_dl_wr"},      32'(dl_wr),      32'd0);
    check({tag, "_dl_addr"},    32'(dl_addr),    32'd0);
    check({tag, "_dl_data"},    32'(dl_data),    32'd0);
    check({tag, "_wait"},       32'(ioctl_wait), 32'd0);
    check({tag, "_load_err"},   32'(load_error), 32'd0);
    check({tag, "_count"},      32'(byte_count), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    tick(); tick();
    check_reset_values("rst");
    RESET = 1'b0;
    tick();

    // Wrong index in IDLE: 100 writes, none accepted.
    ioctl_download = 1'b1; ioctl_index = 8'd1; ioctl_wr = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 100; i++) begin
      ioctl_addr = 25'(i); ioctl_dout = 8'(i);
      tick();
      if (dl_wr) wr_seen++;
    end
    check("idx_idle_no_wr", 32'(wr_seen), 32'd0);
    check("idx_idle_count", 32'(byte_count), 32'd0);
    check("idx_idle_creset", 32'(core_reset), 32'd1);
    check("idx_idle_loaded", 32'(rom_loaded), 32'd0);
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    tick();

    // Enter LOAD; a write on the entry edge is not accepted.
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h777; ioctl_dout = 8'h77;
    tick();
    check("entry_creset", 32'(core_reset), 32'd1);
    check("entry_no_wr", 32'(dl_wr), 32'd0);
    check("entry_count", 32'(byte_count), 32'd0);

    // Write pipeline.
    ioctl_addr = 25'h12005; ioctl_dout = 8'hA5;
    tick();
    check("pipe_wr", 32'(dl_wr), 32'd1);
    check("pipe_addr", 32'(dl_addr), 32'h12005);
    check("pipe_data", 32'(dl_data), 32'hA5);
    check("pipe_count", 32'(byte_count), 32'd1);
    ioctl_wr = 1'b0; ioctl_addr = 25'h0; ioctl_dout = 8'h0;
    wait_hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (ioctl_wait) wait_hi++;
      if (i == 1) begin
        check("pipe_wr_one_cycle", 32'(dl_wr), 32'd0);
        check("pipe_addr_stable", 32'(dl_addr), 32'h12005);
      end
      tick();
    end
    check("gap_len", 32'(wait_hi), 32'd3);

    // Write injected during wait is accepted and restarts the gap.
    ioctl_wr = 1'b1; ioctl_addr = 25'h20; ioctl_dout = 8'h11;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("inj_wait_up", 32'(ioctl_wait), 32'd1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h21; ioctl_dout = 8'h22;
    tick();
    check("inj_wr", 32'(dl_wr), 32'd1);
    check("inj_count", 32'(byte_count), 32'd3);
    ioctl_wr = 1'b0;
    wait_hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (ioctl_wait) wait_hi++;
      tick();
    end
    check("inj_gap_len", 32'(wait_hi), 32'd3);

    // Finish the full image back-to-back; last byte shares the edge with download low.
    for (int i = 0; i < 61; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h100 + 25'(i); ioctl_dout = 8'(i + 8'h30);
      ioctl_download = (i != 60);
      tick();
      check("b2b_wr", 32'(dl_wr), 32'd1);
      check("b2b_addr", 32'(dl_addr), 32'h100 + 32'(i));
      check("b2b_data", 32'(dl_data), 32'(8'(i + 8'h30)));
    end
    ioctl_wr = 1'b0;
    check("full_count", 32'(byte_count), 32'h40);
    check("hold_wait_low", 32'(ioctl_wait), 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("hold_last_loaded", 32'(rom_loaded), 32'd0);
    check("hold_last_creset", 32'(core_reset), 32'd1);
    tick();
    check("full_loaded", 32'(rom_loaded), 32'd1);
    check("full_creset", 32'(core_reset), 32'd0);
    check("full_err", 32'(load_error), 32'd0);
    check("full_count_run", 32'(byte_count), 32'h40);

    // Wrong index while running.
    ioctl_download = 1'b1; ioctl_index = 8'd1; ioctl_wr = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dl_wr) wr_seen++;
    end
    check("idx_run_no_wr", 32'(wr_seen), 32'd0);
    check("idx_run_loaded", 32'(rom_loaded), 32'd1);
    check("idx_run_count", 32'(byte_count), 32'h40);
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    tick();

    // Reload from RUN with a short image.
    ioctl_download = 1'b1;
    tick();
    check("reload_creset", 32'(core_reset), 32'd1);
    check("reload_loaded", 32'(rom_loaded), 32'd0);
    check("reload_count", 32'(byte_count), 32'd0);
    check("reload_err", 32'(load_error), 32'd0);
    for (int i = 0; i < 32; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i);
      ioctl_download = (i != 31);
      tick();
    end
    ioctl_wr = 1'b0;
    check("short_count", 32'(byte_count), 32'h20);
    for (int i = 0; i < 16; i++) tick();
    check("short_loaded", 32'(rom_loaded), 32'd1);
    check("short_err", 32'(load_error), 32'd1);
    check("short_creset", 32'(core_reset), 32'd0);

    // Reset in the middle of a load.
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h3000 + 25'(i); ioctl_dout = 8'(i);
      tick();
    end
    check("mid_count", 32'(byte_count), 32'h100);
    RESET = 1'b1; ioctl_download = 1'b0;
    tick();
    check_reset_values("midrst");
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_no_wr", 32'(dl_wr), 32'd0);
    check("post_rst_count", 32'(byte_count), 32'd0);
    check("post_rst_creset", 32'(core_reset), 32'd1);
    check("post_rst_loaded", 32'(rom_loaded), 32'd0);
    ioctl_wr = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
# rom_load_ctrl

Sequencer for the SD-card ROM download path in front of the selector and the dual-port EPROM/PROM bank. It qualifies the ioctl download stream by index, registers address/data into a one-cycle write pulse for the EPROM bank, paces the HPS with `ioctl_wait`, and counts bytes against the expected image size. It also holds the game core in reset from power-up through the load and for a settle period afterwards.

## Interface
Parameters:
- `ROM_INDEX`, default 8'd0: `ioctl_index` value that identifies the ROM image.
- `ROM_SIZE`, default 25'h58300: expected byte count of a complete image, covering CPU, audio, chars, tiles, sprites and colour PROMs.
- `HOLD_CYCLES`, default 16: cycles `core_reset` stays high after the download ends. Must be 1 or more.
- `WR_GAP`, default 0: `ioctl_wait` cycles inserted after each accepted write. 0 disables pacing.

Ports:
- `CLK` in 1: single clock; download and core share this domain.
- `RESET` in 1: synchronous, active-high.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: image index.
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: back-pressure to the HPS.
- `dl_wr` out 1: write pulse to the EPROM bank; it is ANDed with each device's chip select.
- `dl_addr` out 25: registered address, driven to the selector and to `ADDR_DL`.
- `dl_data` out 8: registered data, driven to `DATA_IN`.
- `core_reset` out 1: reset for the CPUs and video.
- `rom_loaded` out 1: image loaded, core running.
- `load_error` out 1: the last load's byte count was not equal to `ROM_SIZE`.
- `byte_count` out 25: bytes accepted in the current or last load.

## Operation
- States are IDLE, LOAD, HOLD and RUN.
- IDLE: entered on reset. `core_reset`=1, `rom_loaded`=0.
  - Moves to LOAD when `ioctl_download`=1 and `ioctl_index`==`ROM_INDEX`.
  - On entry to LOAD, clears `byte_count` and `load_error`.
- LOAD: `core_reset`=1.
  - Each cycle with `ioctl_wr`=1 is an accepted write.
  - On an accepted write: `dl_addr`<=`ioctl_addr`, `dl_data`<=`ioctl_dout`, `dl_wr`<=1, and `byte_count` increments.
  - `byte_count` saturates at 25'h1FFFFFF.
  - When `ioctl_download`=0 is sampled, the state moves to HOLD. A write in that same cycle is still accepted.
- HOLD: lasts exactly `HOLD_CYCLES` cycles. `core_reset`=1 and `rom_loaded`=0 throughout.
  - On exit, `load_error`<=(`byte_count`!=`ROM_SIZE`), and the state moves to RUN.
- RUN: `core_reset`=0, `rom_loaded`=1.
  - A new matching download (`ioctl_download`=1 with index==`ROM_INDEX`) returns to LOAD. On that transition `core_reset` goes to 1 and `rom_loaded` to 0, and `byte_count`/`load_error` are cleared.
- Downloads with a non-matching index are ignored in every state; no state or output changes.
- `ioctl_wr` outside LOAD is ignored: no `dl_wr` and no count.
- Pacing with `WR_GAP`>0:
  - An accepted write loads a gap counter with `WR_GAP`.
  - `ioctl_wait`=1 while the counter is non-zero; the counter decrements each cycle.
  - A write that arrives while `ioctl_wait`=1 is still accepted and reloads the counter.
  - `ioctl_wait` is forced to 0 outside LOAD.
- Address decode stays in the selector. This block does not qualify `dl_addr` ranges.

## Timing
- Reset values: state=IDLE, `dl_wr`=0, `dl_addr`=0, `dl_data`=0, `ioctl_wait`=0, `core_reset`=1, `rom_loaded`=0, `load_error`=0, `byte_count`=0, gap counter=0.
- `RESET` mid-load returns to IDLE on the next edge. Partially written ROM contents are left in place, `core_reset` stays 1, and nothing completes until a fresh download.
- Write latency: `ioctl_wr` sampled at edge n gives `dl_wr`=1 during cycle n+1, for exactly one cycle. `dl_addr`/`dl_data` stay stable until the next accepted write.
- Back-to-back writes on consecutive cycles give `dl_wr` high on consecutive cycles; each carries its own address and data.
- `byte_count` reflects a write one cycle after it is sampled.
- Download end: if `ioctl_download`=0 is sampled at edge k, HOLD spans cycles k+1 to k+HOLD_CYCLES. RUN, `rom_loaded`=1, `core_reset`=0 and valid `load_error` all appear at cycle k+HOLD_CYCLES+1.
- Entering LOAD: `ioctl_download` rising is sampled at edge m, and `core_reset`=1 at m+1. A write in cycle m is not accepted, because the state is not yet LOAD.
- `ioctl_wait` rises the cycle after an accepted write and stays high for `WR_GAP` cycles.

## Test plan
- **Full load, default parameters.** Stream 0x58300 bytes at index 0, one per cycle, then drop `ioctl_download`.
  - Expect `byte_count`=0x58300 and `load_error`=0.
  - Expect `rom_loaded` to rise exactly 17 cycles after the edge that samples download low.
- **Write pipeline.** Write addr 0x12005 with data 0xA5.
  - Expect `dl_wr` to pulse one cycle later with `dl_addr`=0x12005 and `dl_data`=0xA5.
  - Read back eprom_3 (char ROM) offset 0x0005 and expect 0xA5.
- **Short image.** Send 0x58000 bytes, then end the download.
  - Expect `load_error`=1 when `rom_loaded` rises.
  - Expect `core_reset` to still release.
- **Wrong index.** `ioctl_index`=1 with 100 writes.
  - Expect no `dl_wr`, `byte_count`=0, and the state stays IDLE/RUN unchanged.
- **Pacing, `WR_GAP`=3.**
  - After each accepted write, `ioctl_wait` is high for exactly 3 cycles.
  - A write injected during wait is still counted.
- **Reset mid-load, then reload from RUN.**
  - `RESET` after 0x100 bytes: expect IDLE with all reset values.
  - A second download from RUN: expect `core_reset` to go to 1 and `byte_count` to be cleared at the LOAD entry.
